// File: rtl/fsk_modulator_framed.sv
// Phase-continuous binary FSK modulator with built-in symbol timing and a valid/ready bit input.
// Optional feature macro FSK_IDLE_MUTE_EN: output held low and tone counter parked while idle.

module fsk_modulator_framed #(
    parameter int CNT_W    = 8,
    parameter int BAUD_W   = 16,
    parameter int BAUD_DIV = 434,
    parameter int N_MARK   = 12,
    parameter int N_SPACE  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_mark,
    input  logic [CNT_W-1:0] cfg_space,
    output logic             busy,
    output logic             sym_start,
    output logic             fsk_out
);

    typedef enum logic {IDLE, SYMBOL} state_t;

    localparam logic [BAUD_W-1:0] BaudLast = BAUD_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  MarkRst  = CNT_W'(N_MARK);
    localparam logic [CNT_W-1:0]  SpaceRst = CNT_W'(N_SPACE);

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
    logic              curBit_q, curBit_d;
    logic              busy_q, busy_d;
    logic              symStart_q, symStart_d;
    logic [CNT_W-1:0]  toneCnt_q, toneCnt_d;
    logic              fsk_q, fsk_d;
    logic [CNT_W-1:0]  actMark_q, actMark_d;
    logic [CNT_W-1:0]  actSpace_q, actSpace_d;
    logic [CNT_W-1:0]  shdMark_q, shdMark_d;
    logic [CNT_W-1:0]  shdSpace_q, shdSpace_d;

    logic             symLast;
    logic             accept;
    logic             loadAct;
    logic [CNT_W-1:0] toneLimit;

    assign symLast   = (state_q == SYMBOL) && (baudCnt_q == BaudLast);
    assign bit_ready = (state_q == IDLE) || symLast;
    assign accept    = bit_valid && bit_ready;

    assign busy      = busy_q;
    assign sym_start = symStart_q;
    assign fsk_out   = fsk_q;

    // Symbol sequencing; a handshake in IDLE or on the last symbol clock starts a fresh symbol.
    always_comb begin
        state_d    = state_q;
        baudCnt_d  = baudCnt_q;
        curBit_d   = curBit_q;
        busy_d     = busy_q;
        symStart_d = 1'b0;
        loadAct    = 1'b0;

        case (state_q)
            IDLE: begin
                curBit_d = 1'b1;
                busy_d   = 1'b0;
                loadAct  = 1'b1;
            end
            SYMBOL: begin
                baudCnt_d = baudCnt_q + BAUD_W'(1);
                if (symLast && !bit_valid) begin
                    state_d   = IDLE;
                    baudCnt_d = '0;
                    curBit_d  = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d    = SYMBOL;
            baudCnt_d  = '0;
            curBit_d   = bit_in;
            busy_d     = 1'b1;
            symStart_d = 1'b1;
            loadAct    = 1'b1;
        end
    end

    // Shadow limits; a zero half-period would stall the tone, so it is stored as one.
    always_comb begin
        shdMark_d  = shdMark_q;
        shdSpace_d = shdSpace_q;
        if (cfg_we) begin
            shdMark_d  = (cfg_mark == '0) ? CNT_W'(1) : cfg_mark;
            shdSpace_d = (cfg_space == '0) ? CNT_W'(1) : cfg_space;
        end
        actMark_d  = loadAct ? shdMark_q : actMark_q;
        actSpace_d = loadAct ? shdSpace_q : actSpace_q;
    end

    // Tone counter keeps running across tone changes so the waveform never jumps phase.
    always_comb begin
        toneLimit = curBit_q ? actMark_q : actSpace_q;
        toneCnt_d = toneCnt_q + CNT_W'(1);
        fsk_d     = fsk_q;
        if (toneCnt_q >= toneLimit) begin
            toneCnt_d = '0;
            fsk_d     = ~fsk_q;
        end
`ifdef FSK_IDLE_MUTE_EN
        if (state_q == IDLE) begin
            toneCnt_d = '0;
            fsk_d     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            curBit_q   <= 1'b1;
            busy_q     <= 1'b0;
            symStart_q <= 1'b0;
            toneCnt_q  <= '0;
            fsk_q      <= 1'b0;
            actMark_q  <= MarkRst;
            actSpace_q <= SpaceRst;
            shdMark_q  <= MarkRst;
            shdSpace_q <= SpaceRst;
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            curBit_q   <= curBit_d;
            busy_q     <= busy_d;
            symStart_q <= symStart_d;
            toneCnt_q  <= toneCnt_d;
            fsk_q      <= fsk_d;
            actMark_q  <= actMark_d;
            actSpace_q <= actSpace_d;
            shdMark_q  <= shdMark_d;
            shdSpace_q <= shdSpace_d;
        end
    end

endmodule

// File: tb/tb_fsk_modulator_framed.sv
// Scoreboard bench for fsk_modulator_framed: the driver queues one expectation per symbol,
// and a monitor checks each symbol when its sym_start pulse appears.

module tb_fsk_modulator_framed;

    localparam int BAUD_DIV = 434;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic       cfg_we;
    logic [7:0] cfg_mark;
    logic [7:0] cfg_space;
    logic       busy;
    logic       sym_start;
    logic       fsk_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int expHalf;
        bit fromIdle;
        bit backToBack;
        bit last;
        int abortIdx;
    } symExp_t;

    symExp_t sbq[$];

    // Monitor-owned sampling state, updated once per falling edge.
    int   sampleIdx  = 0;
    int   lastToggle = 0;
    int   lastStart  = -100000;
    logic prevFsk    = 1'b0;
    logic prevBusy   = 1'b0;
    logic toggled    = 1'b0;

    fsk_modulator_framed #(
        .CNT_W   (8),
        .BAUD_W  (16),
        .BAUD_DIV(BAUD_DIV),
        .N_MARK  (12),
        .N_SPACE (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .cfg_we   (cfg_we),
        .cfg_mark (cfg_mark),
        .cfg_space(cfg_space),
        .busy     (busy),
        .sym_start(sym_start),
        .fsk_out  (fsk_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Advance one sample; track cycles since the tone counter was last zero.
    task automatic tick();
        @(negedge clk);
        sampleIdx++;
        toggled = (fsk_out != prevFsk);
        prevFsk = fsk_out;
        if (rst || toggled) lastToggle = sampleIdx;
        if (!rst && !busy && !prevBusy) begin
            checkOutput("idleReady", bit_ready, 1);
`ifdef FSK_IDLE_MUTE_EN
            checkOutput("idleMuted", fsk_out, 0);
`endif
        end
        prevBusy = busy;
    endtask

    // Called on the sym_start sample; returns on the sample after the symbol (or at reset).
    task automatic processSymbol(input symExp_t d);
        int  cnt0;
        int  lim;
        int  expFirst;
        int  firstOff = -1;
        int  lastTog  = -1;
        int  nTog     = 0;
        int  badBusy  = 0;
        int  badReady = 0;
        int  badPulse = 0;
        int  badInt   = 0;
        int  abortAt  = -1;
        bit  aborted  = 1'b0;
        cnt0 = sampleIdx - lastToggle;
        lim  = d.expHalf - 1;
        if (d.backToBack) checkOutput("symGap", sampleIdx - lastStart, BAUD_DIV);
        lastStart = sampleIdx;
        expFirst = (cnt0 >= lim) ? 1 : (lim - cnt0 + 1);
`ifdef FSK_IDLE_MUTE_EN
        if (d.fromIdle) expFirst = d.expHalf;
`endif
        for (int i = 0; i < BAUD_DIV; i++) begin
            if (i > 0) tick();
            if (rst) begin
                aborted = 1'b1;
                abortAt = i;
                break;
            end
            if (busy !== 1'b1) badBusy++;
            if (bit_ready !== (i == BAUD_DIV - 1)) badReady++;
            if (i > 0 && sym_start) badPulse++;
            if (i > 0 && toggled) begin
                nTog++;
                if (firstOff < 0) firstOff = i;
                else if (sampleIdx - lastTog != d.expHalf) badInt++;
                lastTog = sampleIdx;
            end
        end
        checkOutput("symAborted", int'(aborted), int'(d.abortIdx >= 0));
        checkOutput("symBusyLow", badBusy, 0);
        checkOutput("symReadyPattern", badReady, 0);
        checkOutput("symExtraPulse", badPulse, 0);
        checkOutput("symHalfPeriod", badInt, 0);
        if (aborted) begin
            checkOutput("abortIndex", abortAt, d.abortIdx);
            checkOutput("abortBusy", busy, 0);
            checkOutput("abortFsk", fsk_out, 0);
            checkOutput("abortSymStart", sym_start, 0);
        end else begin
            checkOutput("symFirstToggle", firstOff, expFirst);
            checkOutput("symEnoughToggles", int'(nTog >= 2), 1);
            tick();
            if (d.last) begin
                checkOutput("endSymStart", sym_start, 0);
                checkOutput("endBusy", busy, 0);
                checkOutput("endReady", bit_ready, 1);
            end else begin
                checkOutput("nextSymStart", sym_start, 1);
            end
        end
    endtask

    initial begin : monitor
        symExp_t d;
        forever begin
            tick();
            while (sym_start && !rst) begin
                if (sbq.size() == 0) begin
                    checkOutput("pendingSymbols", sbq.size(), 1);
                    break;
                end
                d = sbq.pop_front();
                processSymbol(d);
            end
        end
    end

    // Present one bit at a falling edge and return on the first sample of its symbol.
    task automatic applyStimulus(input logic b, input int half, input bit fromIdle,
                                 input bit b2b, input bit last, input int abortIdx,
                                 input bit cfgAt, input logic [7:0] cm, input logic [7:0] cs);
        symExp_t e;
        int      waited = 0;
        e.expHalf    = half;
        e.fromIdle   = fromIdle;
        e.backToBack = b2b;
        e.last       = last;
        e.abortIdx   = abortIdx;
        sbq.push_back(e);
        bit_in    = b;
        bit_valid = 1'b1;
        while (!bit_ready && waited < 2 * BAUD_DIV) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("handshakeReady", bit_ready, 1);
        if (cfgAt) begin
            cfg_we    = 1'b1;
            cfg_mark  = cm;
            cfg_space = cs;
        end
        @(negedge clk);
        cfg_we = 1'b0;
        if (last) bit_valid = 1'b0;
    endtask

    // Idle window starting right after reset release: mark tone at reset limits.
    task automatic checkIdle(input int n, input int expToggles);
        logic prev;
        int   first  = -1;
        int   last   = -1;
        int   nt     = 0;
        int   badInt = 0;
        prev = fsk_out;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (fsk_out != prev) begin
                nt++;
                if (first < 0) first = i;
                else if (i - last != 13) badInt++;
                last = i;
                prev = fsk_out;
            end
        end
`ifdef FSK_IDLE_MUTE_EN
        checkOutput("idleToggles", nt, 0);
`else
        checkOutput("idleFirstToggle", first, 13);
        checkOutput("idleInterval", badInt, 0);
        checkOutput("idleToggles", nt, expToggles);
`endif
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin : stimulus
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        cfg_we    = 1'b0;
        cfg_mark  = 8'd0;
        cfg_space = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("rstFsk", fsk_out, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstSymStart", sym_start, 0);
        checkOutput("rstReady", bit_ready, 1);
        #1 rst = 1'b0;
        checkIdle(200, 15);

        // Single space bit from idle.
        applyStimulus(1'b0, 33, 1, 0, 1, -1, 0, 8'd0, 8'd0);
        repeat (BAUD_DIV + 60) @(negedge clk);

        // Back-to-back stream 1,0,1,1,0.
        applyStimulus(1'b1, 13, 1, 0, 0, -1, 0, 8'd0, 8'd0);
        applyStimulus(1'b0, 33, 0, 1, 0, -1, 0, 8'd0, 8'd0);
        applyStimulus(1'b1, 13, 0, 1, 0, -1, 0, 8'd0, 8'd0);
        applyStimulus(1'b1, 13, 0, 1, 0, -1, 0, 8'd0, 8'd0);
        applyStimulus(1'b0, 33, 0, 1, 1, -1, 0, 8'd0, 8'd0);
        repeat (BAUD_DIV + 40) @(negedge clk);

        // Mid-symbol config write: mark=5, space=0 (stored as 1) from the following symbol.
        applyStimulus(1'b1, 13, 1, 0, 0, -1, 0, 8'd0, 8'd0);
        applyStimulus(1'b0, 33, 0, 1, 0, -1, 0, 8'd0, 8'd0);
        repeat (100) @(negedge clk);
        cfg_we    = 1'b1;
        cfg_mark  = 8'd5;
        cfg_space = 8'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        applyStimulus(1'b1, 6, 0, 1, 0, -1, 0, 8'd0, 8'd0);
        applyStimulus(1'b0, 2, 0, 1, 1, -1, 0, 8'd0, 8'd0);
        repeat (BAUD_DIV + 40) @(negedge clk);

        // Config write on the boundary cycle: next symbol keeps old limits.
        applyStimulus(1'b0, 2, 1, 0, 0, -1, 0, 8'd0, 8'd0);
        applyStimulus(1'b1, 6, 0, 1, 0, -1, 1, 8'd9, 8'd20);
        applyStimulus(1'b1, 10, 0, 1, 1, -1, 0, 8'd0, 8'd0);
        repeat (BAUD_DIV + 40) @(negedge clk);

        // Reset at baud count 200 of a space symbol (space limit 20 -> half 21).
        applyStimulus(1'b0, 21, 1, 0, 1, 201, 0, 8'd0, 8'd0);
        repeat (200) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("asyncRstFsk", fsk_out, 0);
        checkOutput("asyncRstBusy", busy, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        checkIdle(100, 7);
        applyStimulus(1'b0, 33, 1, 0, 1, -1, 0, 8'd0, 8'd0);
        repeat (BAUD_DIV + 40) @(negedge clk);

        checkOutput("scoreboardDrained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsk_modulator_framed.md
Name: fsk_modulator_framed

Overview:
- Parametrised, phase-continuous binary FSK modulator with built-in symbol timing and a valid/ready bit input.
- An upstream UART/framer pushes one bit per handshake. The block holds each bit for exactly BAUD_DIV clocks and drives the GPIO tone output.
- Tone half-periods are runtime-programmable through shadow registers that take effect only on symbol boundaries. Idle line sends the mark tone.

Parameters:
- CNT_W, 8, width of the tone counter and tone config fields
- BAUD_W, 16, width of the symbol-timer counter
- BAUD_DIV, 434, clocks per symbol (50 MHz / 115200); legal range 2..2^BAUD_W-1
- N_MARK, 12, reset half-period limit for bit=1
- N_SPACE, 32, reset half-period limit for bit=0

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- bit_in  in  1  data bit to transmit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  block accepts bit_in this cycle
- cfg_we  in  1  write strobe for tone config shadow registers
- cfg_mark  in  CNT_W  new mark half-period limit
- cfg_space  in  CNT_W  new space half-period limit
- busy  out  1  a symbol is in progress
- sym_start  out  1  one-cycle pulse on the first clock of each symbol
- fsk_out  out  1  FSK waveform to GPIO

Behaviour:
- Reset (async, active-high) values:
  - fsk_out=0, tone counter=0, baud counter=0, state=IDLE, cur_bit=1, busy=0, sym_start=0.
  - Active and shadow limits load N_MARK and N_SPACE.
- Tone generator:
  - limit = cur_bit ? act_mark : act_space.
  - Each clk: if tone_cnt >= limit, then tone_cnt<=0 and fsk_out toggles; else tone_cnt++.
  - Output period is 2*(limit+1) clocks.
  - Tone counter and fsk_out are never cleared on a tone or symbol change (phase continuity). If the counter is above a new, smaller limit, it toggles on the next clock.
- States: IDLE, SYMBOL.
  - IDLE: bit_ready=1, busy=0, cur_bit=1 (mark tone runs).
  - IDLE to SYMBOL on bit_valid & bit_ready. On the next edge:
    - cur_bit<=bit_in, baud_cnt<=0, busy<=1, sym_start<=1 for one cycle.
    - Shadow limits are copied to active.
  - SYMBOL: baud_cnt increments each clock. bit_ready = (baud_cnt == BAUD_DIV-1), combinational from registered state.
  - Last cycle with bit_valid=1: back-to-back handshake. The next symbol starts the following clock with no gap. The symbol boundary steps are repeated: baud_cnt<=0, sym_start pulse, cur_bit update, active<=shadow.
  - Last cycle with bit_valid=0: go to IDLE, cur_bit<=1, busy<=0.
  - Each symbol is exactly BAUD_DIV clocks of cur_bit, measured from the sym_start cycle.
- bit_in and bit_valid are ignored while bit_ready=0. Upstream must hold bit_in and bit_valid until the handshake.
- Config:
  - cfg_we writes the shadow registers.
  - A zero value written to cfg_mark or cfg_space is stored as 1.
  - Shadow is copied to active at every symbol start, and on the clock after cfg_we while in IDLE.
  - When cfg_we and a symbol boundary fall on the same cycle, the boundary copies the old shadow. The new value applies at the next boundary, or in IDLE as above.
  - Active limits never change mid-symbol.
- Mid-operation reset: all state returns to reset values immediately. Any in-flight symbol is abandoned with no completion pulse.

Optional Feature:
- Macro: FSK_IDLE_MUTE_EN.
- Defined:
  - In IDLE, fsk_out is forced 0 and tone_cnt is held at 0.
  - The tone starts from phase 0 on the first SYMBOL clock.
  - On return to IDLE, fsk_out goes 0 on the next clock.
- Undefined: mark tone runs continuously in IDLE, as above.

Test Plan:
- Reset, then idle 200 clocks -> fsk_out toggles every 13 clks (period 26), bit_ready=1, busy=0, sym_start never pulses.
- Single bit 0 handshake -> sym_start pulses once; toggles every 33 clks for 434 clks; bit_ready high only on clock 434; then IDLE and mark tone; no glitch on fsk_out at either boundary.
- Streaming bits 1,0,1,1,0 with bit_valid held high -> 5 sym_start pulses spaced exactly 434 clks; busy continuously 1 for 2170 clks; tone counter never reset at boundaries.
- cfg_we with mark=5, space=0 during symbol 1 of a stream -> symbol 1 unchanged; from symbol 2 mark period is 12 clks and space period is 4 clks (0 stored as 1).
- Assert rst mid-symbol at baud_cnt=200 -> fsk_out=0 and busy=0 immediately; after release, IDLE with N_MARK/N_SPACE restored.
- Build with FSK_IDLE_MUTE_EN -> fsk_out=0 throughout IDLE; first toggle 33 clks after sym_start for bit 0.
